// File: rtl/vdp18_scandoubler.sv
// VDP line doubler: stores 4-bit colour indices of one input line and
// replays the previous line twice at the doubled pixel rate with new sync.
module vdp18_scandoubler #(
   parameter int hsync_start_g = 8,
   parameter int hsync_width_g = 40
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       clk_en_5m37_i,
   input  logic       clk_en_10m7_i,
   input  logic [3:0] col_i,
   input  logic       hblank_n_i,
   input  logic       vblank_n_i,
   output logic [3:0] col_o,
   output logic       hblank_n_o,
   output logic       vblank_n_o,
   output logic       hsync_n_o
);

   localparam logic [8:0] max_c      = 9'd511;
   localparam logic [9:0] hs_start_c = 10'(hsync_start_g);
   localparam logic [9:0] hs_end_c   = 10'(hsync_start_g + hsync_width_g);

   logic [3:0] buf0 [512];
   logic [3:0] buf1 [512];

   logic       wr_sel;
   logic       hbl_prev_q;
   logic       vbl_smp_q;
   logic       vbl_q;
   logic [8:0] in_x;
   logic [8:0] in_tot;
   logic [8:0] act_len_q;
   logic [8:0] tot_q;
   logic [8:0] out_h;

   logic       line_start;
   logic       wr_en;
   logic       wr_buf;
   logic [8:0] wr_addr;
   logic [3:0] rd_pix;
   logic       pix_act;
   logic       sync_act;
   logic [9:0] out_x;
   logic [9:0] sync_lo;
   logic [9:0] sync_hi;

   // Line start detection and write-port steering. The line-start pixel
   // is already active, so it goes to address 0 of the buffer about to
   // become the write buffer.
   always_comb begin
      line_start = clk_en_5m37_i & hblank_n_i & ~hbl_prev_q;
      wr_en      = clk_en_5m37_i & hblank_n_i &
                   (line_start | (in_x != max_c));
      wr_buf     = line_start ? ~wr_sel : wr_sel;
      wr_addr    = line_start ? 9'd0 : in_x;
   end

   // Input-side counters and per-line capture of length and vblank.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_sel     <= 1'b0;
         hbl_prev_q <= 1'b0;
         vbl_smp_q  <= 1'b0;
         vbl_q      <= 1'b0;
         in_x       <= 9'd0;
         in_tot     <= 9'd0;
         act_len_q  <= 9'd0;
         tot_q      <= 9'd0;
      end else if (clk_en_5m37_i) begin
         hbl_prev_q <= hblank_n_i;
         if (line_start) begin
            act_len_q <= in_x;
            tot_q     <= in_tot;
            vbl_q     <= vbl_smp_q;
            vbl_smp_q <= vblank_n_i;
            wr_sel    <= ~wr_sel;
            in_x      <= 9'd1;
            in_tot    <= 9'd1;
         end else begin
            if (hblank_n_i && in_x != max_c)
               in_x <= in_x + 9'd1;
            if (in_tot != max_c)
               in_tot <= in_tot + 9'd1;
         end
      end
   end

   // Ping-pong line storage; contents need no reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         if (wr_buf)
            buf1[wr_addr] <= col_i;
         else
            buf0[wr_addr] <= col_i;
      end
   end

   // Read side of the buffer not being written, plus active/sync decode.
   always_comb begin
      rd_pix   = wr_sel ? buf0[out_h] : buf1[out_h];
      out_x    = {1'b0, out_h};
      sync_lo  = {1'b0, act_len_q} + hs_start_c;
      sync_hi  = {1'b0, act_len_q} + hs_end_c;
      pix_act  = (out_h < act_len_q) & vbl_q & (tot_q != 9'd0);
      sync_act = (tot_q != 9'd0) & (out_x >= sync_lo) & (out_x < sync_hi);
   end

   // Output pixel counter: restart at line start, wrap at the stored length.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         out_h <= 9'd0;
      end else if (line_start) begin
         out_h <= 9'd0;
      end else if (clk_en_10m7_i) begin
         if (tot_q == 9'd0 || out_h == tot_q - 9'd1)
            out_h <= 9'd0;
         else
            out_h <= out_h + 9'd1;
      end
   end

   // Registered outputs, all updated together to stay aligned.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         col_o      <= 4'd0;
         hblank_n_o <= 1'b0;
         vblank_n_o <= 1'b0;
         hsync_n_o  <= 1'b1;
      end else if (clk_en_10m7_i) begin
         col_o      <= pix_act ? rd_pix : 4'd0;
         hblank_n_o <= (out_h < act_len_q);
         vblank_n_o <= vbl_q;
         hsync_n_o  <= ~sync_act;
      end
   end

endmodule

// File: tb/tb_vdp18_scandoubler.sv
// Bench for vdp18_scandoubler: a behavioural line model queues the
// expected output for every output enable and the DUT output is checked.
module tb_vdp18_scandoubler;

   localparam int HS = 8;
   localparam int HW = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en5 = 1'b0;
   logic       en10 = 1'b0;
   logic [3:0] col = 4'd0;
   logic       hbl = 1'b0;
   logic       vbl = 1'b0;
   logic [3:0] col_o;
   logic       hblank_n_o;
   logic       vblank_n_o;
   logic       hsync_n_o;

   int n_chk = 0;
   int n_bad = 0;
   string tag_now = "init";

   logic [6:0] sb [$];

   int         m_wrx, m_tot_in, m_act, m_tot, m_oh;
   logic       m_hbp, m_vsmp, m_vbl;
   logic [3:0] m_cur  [512];
   logic [3:0] m_done [512];

   vdp18_scandoubler #(
      .hsync_start_g(HS),
      .hsync_width_g(HW)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (rst_n),
      .clk_en_5m37_i(en5),
      .clk_en_10m7_i(en10),
      .col_i        (col),
      .hblank_n_i   (hbl),
      .vblank_n_i   (vbl),
      .col_o        (col_o),
      .hblank_n_o   (hblank_n_o),
      .vblank_n_o   (vblank_n_o),
      .hsync_n_o    (hsync_n_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] got,
                      input logic [6:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got col/hb/vb/hs=%h/%b/%b/%b want %h/%b/%b/%b",
                  tag, $time, got[6:3], got[2], got[1], got[0],
                  exp[6:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic model_reset();
      m_wrx = 0; m_tot_in = 0; m_act = 0; m_tot = 0; m_oh = 0;
      m_hbp = 1'b0; m_vsmp = 1'b0; m_vbl = 1'b0;
      sb.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      en5 = 1'b0; en10 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk({tag_now, "_rst"}, {col_o, hblank_n_o, vblank_n_o, hsync_n_o},
          7'b0000_001);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: drive inputs, queue the expected output, then compare.
   task automatic cyc(input logic e5, input logic e10, input logic [3:0] c,
                      input logic hb, input logic vb);
      logic       ls;
      logic       a;
      logic [6:0] e;
      @(negedge clk);
      en5 = e5; en10 = e10; col = c; hbl = hb; vbl = vb;
      ls = e5 && hb && !m_hbp;
      if (e10) begin
         a = (m_oh < m_act) && m_vbl && (m_tot != 0);
         e[6:3] = a ? m_done[m_oh] : 4'd0;
         e[2] = (m_oh < m_act);
         e[1] = m_vbl;
         e[0] = !((m_tot != 0) && (m_oh >= m_act + HS) &&
                  (m_oh < m_act + HS + HW));
         sb.push_back(e);
         if (ls || m_tot == 0 || m_oh == m_tot - 1)
            m_oh = 0;
         else
            m_oh++;
      end
      if (e5) begin
         if (ls) begin
            m_act = m_wrx;
            m_tot = m_tot_in;
            m_vbl = m_vsmp;
            m_vsmp = vb;
            m_done = m_cur;
            m_cur[0] = c;
            m_wrx = 1;
            m_tot_in = 1;
         end else begin
            if (hb && m_wrx < 511) begin
               m_cur[m_wrx] = c;
               m_wrx++;
            end
            if (m_tot_in < 511)
               m_tot_in++;
         end
         m_hbp = hb;
      end
      @(posedge clk);
      #1;
      if (e10)
         chk(tag_now, {col_o, hblank_n_o, vblank_n_o, hsync_n_o},
             sb.pop_front());
   endtask

   task automatic pixel(input logic [3:0] c, input logic hb, input logic vb);
      cyc(1'b1, 1'b1, c, hb, vb);
      cyc(1'b0, 1'b0, c, hb, vb);
      cyc(1'b0, 1'b1, c, hb, vb);
      cyc(1'b0, 1'b0, c, hb, vb);
   endtask

   // mode 0: col = x mod 16, mode 1: random colours. n = pixels driven.
   task automatic line(input int tot, input int act, input logic vb,
                       input int mode, input int n);
      logic [3:0] c;
      for (int i = 0; i < n && i < tot; i++) begin
         if (i < act && mode == 0)
            c = 4'(i % 16);
         else
            c = 4'($urandom_range(0, 15));
         pixel(c, (i < act), vb);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         m_cur[i] = 4'd0;
         m_done[i] = 4'd0;
      end
      model_reset();
      tag_now = "reset";
      do_reset();

      tag_now = "t1_nominal";
      repeat (4) line(342, 256, 1'b1, 0, 342);

      tag_now = "t3_vertical";
      repeat (2) line(342, 256, 1'b0, 1, 342);
      repeat (2) line(342, 256, 1'b1, 1, 342);

      tag_now = "t4_midreset";
      line(342, 256, 1'b1, 1, 120);
      do_reset();
      repeat (3) line(342, 256, 1'b1, 0, 342);

      tag_now = "saturate";
      line(530, 515, 1'b1, 1, 530);
      repeat (2) line(342, 256, 1'b1, 1, 342);

      tag_now = "t5_short";
      repeat (3) line(300, 200, 1'b1, 1, 300);
      tag_now = "t5_stuck";
      line(700, 0, 1'b1, 1, 700);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
